// File: rtl/exibe_sequencia.sv
// exibe_sequencia -- plays back a stored sequence of jogadas on four LEDs.
//
// Each jogada is read from an external memory at address 'endereco'. It is
// lit for T_ON cycles and then kept dark for T_OFF cycles. Playback stops
// after the jogada whose index matches the limit captured at start.
//
// Ports
//   clock      : single clock, rising edge
//   reset      : asynchronous, active-low reset
//   iniciar    : start request, accepted only while idle
//   parar      : synchronous abort back to idle
//   limite     : index of the last jogada to show, captured at start
//   dado       : memory read data for 'endereco'
//   endereco   : memory address of the current jogada
//   leds       : registered LED drive
//   ativo      : high whenever the machine is not idle
//   pronto     : one-cycle pulse after the last jogada has been shown
//   db_estado  : current state code, for debug
module exibe_sequencia #(
    parameter int T_ON  = 500,
    parameter int T_OFF = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       parar,
    input  logic [3:0] limite,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ativo,
    output logic       pronto,
    output logic [3:0] db_estado
);

    // The counter only ever reaches T_x-1 before the state is left, so
    // clog2 of the longest phase is enough and it can never wrap.
    localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [CW-1:0] ON_LAST  = CW'(T_ON - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(T_OFF - 1);

    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        PREPARA = 4'd1,
        ACENDE  = 4'd2,
        APAGA   = 4'd3,
        PROXIMO = 4'd4,
        FIM     = 4'd5
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    end_q, end_d;
    logic [3:0]    lim_q, lim_d;
    logic [3:0]    leds_q, leds_d;
    logic          ativo_q, ativo_d;
    logic          pronto_q, pronto_d;

    // Next-state, counter, address and LED computation.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = {CW{1'b0}};
        end_d    = end_q;
        lim_d    = lim_q;
        leds_d   = leds_q;

        if (parar && (estado_q != OCIOSO)) begin
            // Abort: drop everything, keep the address where it was.
            estado_d = OCIOSO;
            leds_d   = 4'b0000;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    leds_d = 4'b0000;
                    // parar has priority over iniciar while idle.
                    if (iniciar && !parar) begin
                        lim_d    = limite;
                        end_d    = 4'd0;
                        estado_d = PREPARA;
                    end else begin
                        estado_d = OCIOSO;
                    end
                end
                PREPARA: begin
                    // Memory data for the new address is valid by now.
                    leds_d   = dado;
                    estado_d = ACENDE;
                end
                ACENDE: begin
                    if (cnt_q == ON_LAST) begin
                        leds_d   = 4'b0000;
                        estado_d = APAGA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                APAGA: begin
                    if (cnt_q == OFF_LAST) begin
                        estado_d = PROXIMO;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                PROXIMO: begin
                    // Compare before incrementing so index 15 never wraps.
                    if (end_q == lim_q) begin
                        estado_d = FIM;
                    end else begin
                        end_d    = end_q + 4'd1;
                        estado_d = PREPARA;
                    end
                end
                FIM: begin
                    estado_d = OCIOSO;
                end
                default: begin
                    estado_d = OCIOSO;
                    leds_d   = 4'b0000;
                end
            endcase
        end

        // Status flags are registered from the next state so they line up
        // with db_estado without any input-to-output path.
        ativo_d  = (estado_d != OCIOSO);
        pronto_d = (estado_d == FIM);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            cnt_q    <= {CW{1'b0}};
            end_q    <= 4'd0;
            lim_q    <= 4'd0;
            leds_q   <= 4'b0000;
            ativo_q  <= 1'b0;
            pronto_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            end_q    <= end_d;
            lim_q    <= lim_d;
            leds_q   <= leds_d;
            ativo_q  <= ativo_d;
            pronto_q <= pronto_d;
        end
    end

    assign endereco  = end_q;
    assign leds      = leds_q;
    assign ativo     = ativo_q;
    assign pronto    = pronto_q;
    assign db_estado = estado_q;

endmodule
